// File: rtl/result_drain.sv
// result_drain: consumer side of the result FIFO. Pops one word at a time, presents it on a
// valid/ready stream, tags the final word of each FRAME_LEN-word frame with out_last and
// pulses frame_done once that word has been accepted.
// Optional build macro: RESULT_RELU_EN clamps negative words to zero at capture.
module result_drain #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned FRAME_LEN = 10,
   parameter int unsigned CNT_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_pop,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              frame_done,
   output logic [CNT_W-1:0]  result_cnt,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

   state_e            state;
   logic              can_pop;
   logic              accept;
   logic [DATA_W-1:0] load_word;

   // Word captured in LOAD, optionally clamped at zero.
`ifdef RESULT_RELU_EN
   assign load_word = fifo_data[DATA_W-1] ? '0 : fifo_data;
`else
   assign load_word = fifo_data;
`endif

   // Pop only from IDLE or from SEND in the cycle the held word is accepted, so at most one
   // word is ever in flight; clr blocks any new pop.
   always_comb begin
      accept   = (state == StSend) && out_ready;
      can_pop  = en && !fifo_empty && !clr;
      fifo_pop = can_pop && ((state == StIdle) || accept);
   end

   assign busy = (state != StIdle);

   // Control FSM with registered stream outputs and frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= StIdle;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         result_cnt <= '0;
      end else begin
         frame_done <= 1'b0;
         if (clr) begin
            // Abort drops both the presented word and any word still due in LOAD.
            state      <= StIdle;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            result_cnt <= '0;
         end else begin
            unique case (state)
               StIdle: begin
                  if (fifo_pop) begin
                     state <= StLoad;
                  end
               end
               StLoad: begin
                  out_data  <= load_word;
                  out_valid <= 1'b1;
                  out_last  <= (result_cnt == LastCnt);
                  state     <= StSend;
               end
               StSend: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (result_cnt == LastCnt) begin
                        result_cnt <= '0;
                        frame_done <= 1'b1;
                     end else begin
                        result_cnt <= result_cnt + 1'b1;
                     end
                     state <= fifo_pop ? StLoad : StIdle;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule
